// File: rtl/id_stage_sb_if.sv
// IF/ID -> ID/EX handshake bundle for the registered decode stage.
// master drives the IF slot, flush and EX backpressure; slave is the decode stage.
interface id_stage_sb_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            ex_ready;
    logic            out_valid;
    logic [5:0]      out_alu_op;
    logic [RAW-1:0]  out_rs1;
    logic [RAW-1:0]  out_rs2;
    logic [RAW-1:0]  out_rd;
    logic            out_read_reg1;
    logic            out_read_reg2;
    logic            out_write_reg;
    logic            out_read_mem;
    logic            out_write_mem;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
    logic            stall;

    modport master (
        output in_valid, in_inst, in_pc, flush, ex_ready,
        input  in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
               out_read_reg1, out_read_reg2, out_write_reg, out_read_mem,
               out_write_mem, out_imm, out_pc, out_illegal, stall
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, ex_ready,
        output in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
               out_read_reg1, out_read_reg2, out_write_reg, out_read_mem,
               out_write_mem, out_imm, out_pc, out_illegal, stall
    );
endinterface

// File: rtl/id_stage_sb.sv
// Registered RV32-subset decode stage with a per-register producer-latency
// scoreboard driving load-use and branch-compare stalls.
module id_stage_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    id_stage_sb_if.slave bus
);
    localparam int RAW = $clog2(NREG);
    localparam int CW  = $clog2(LOAD_LAT + 1);

    typedef enum logic [5:0] {
        OP_NONE = 6'd0,  OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_SLL = 6'd3,
        OP_XOR  = 6'd4,  OP_SRL = 6'd5,  OP_OR  = 6'd6,  OP_AND = 6'd7,
        OP_LW   = 6'd8,  OP_ADDI = 6'd9, OP_SW  = 6'd10, OP_BEQ = 6'd11,
        OP_BLT  = 6'd12, OP_BGE = 6'd13, OP_JAL = 6'd14
    } alu_op_e;

    typedef struct packed {
        alu_op_e         op;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic            rr1;
        logic            rr2;
        logic            wr;
        logic            rm;
        logic            wm;
        logic            ill;
        logic [XLEN-1:0] imm;
    } slot_t;

    slot_t           dec, slot_q;
    logic [XLEN-1:0] pc_q;
    logic            vld_q;
    logic            is_br;
    logic [CW-1:0]   cnt [NREG];

    logic [31:0]     inst;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

    assign inst  = bus.in_inst;
    assign f3    = inst[14:12];
    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec   = '0;
        is_br = 1'b0;
        case (inst[6:0])
            7'b0110011: begin
                case (f3)
                    3'b000:  dec.op = (inst[31:25] == 7'd0) ? OP_ADD : OP_SUB;
                    3'b001:  dec.op = OP_SLL;
                    3'b100:  dec.op = OP_XOR;
                    3'b101:  dec.op = OP_SRL;
                    3'b110:  dec.op = OP_OR;
                    3'b111:  dec.op = OP_AND;
                    default: dec.op = OP_NONE;
                endcase
                {dec.rr1, dec.rr2, dec.wr} = 3'b111;
            end
            7'b0000011: begin
                dec.op = OP_LW;   dec.rr1 = 1'b1; dec.wr = 1'b1;
                dec.rm = 1'b1;    dec.imm = imm_i;
            end
            7'b0010011: begin
                dec.op = OP_ADDI; dec.rr1 = 1'b1; dec.wr = 1'b1; dec.imm = imm_i;
            end
            7'b0100011: begin
                dec.op = OP_SW;   dec.rr1 = 1'b1; dec.rr2 = 1'b1;
                dec.wm = 1'b1;    dec.imm = imm_s;
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    default: dec.op = OP_NONE;
                endcase
                {dec.rr1, dec.rr2} = 2'b11;
                dec.imm = imm_b;
                is_br   = 1'b1;
            end
            7'b1101111: begin
                dec.op = OP_JAL;  dec.wr = 1'b1; dec.imm = imm_j;
            end
            default: dec.op = OP_NONE;
        endcase
        // Unrecognised encodings carry only the illegal marker so they never hazard or write.
        if (dec.op == OP_NONE) begin
            dec     = '0;
            dec.ill = 1'b1;
            is_br   = 1'b0;
        end
        dec.rs1 = dec.rr1 ? inst[15 +: RAW] : '0;
        dec.rs2 = dec.rr2 ? inst[20 +: RAW] : '0;
        dec.rd  = dec.wr  ? inst[7  +: RAW] : '0;
    end

    // Branches compare in ID so need the value now; everything else can take EX forwarding.
    logic busy1, busy2, hazard, adv, issue;
    assign busy1  = is_br ? (cnt[dec.rs1] != '0) : (cnt[dec.rs1] > CW'(1));
    assign busy2  = is_br ? (cnt[dec.rs2] != '0) : (cnt[dec.rs2] > CW'(1));
    assign hazard = (dec.rr1 & busy1) | (dec.rr2 & busy2);
    assign adv    = ~vld_q | bus.ex_ready;
    assign issue  = bus.in_valid & bus.in_ready;

    assign bus.in_ready = adv & ~hazard & ~bus.flush;
    assign bus.stall    = bus.in_valid & hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (issue && dec.wr && dec.rd == RAW'(r))
                    cnt[r] <= dec.rm ? CW'(LOAD_LAT) : CW'(1);
                else if (bus.ex_ready && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            slot_q <= '0;
            pc_q   <= '0;
        end else if (bus.flush) begin
            vld_q  <= 1'b0;
            slot_q <= '0;
            pc_q   <= '0;
        end else if (adv) begin
            vld_q  <= bus.in_valid & ~hazard;
            slot_q <= (bus.in_valid & ~hazard) ? dec : '0;
            pc_q   <= (bus.in_valid & ~hazard) ? bus.in_pc : '0;
        end
    end

    assign bus.out_valid     = vld_q;
    assign bus.out_alu_op    = slot_q.op;
    assign bus.out_rs1       = slot_q.rs1;
    assign bus.out_rs2       = slot_q.rs2;
    assign bus.out_rd        = slot_q.rd;
    assign bus.out_read_reg1 = slot_q.rr1;
    assign bus.out_read_reg2 = slot_q.rr2;
    assign bus.out_write_reg = slot_q.wr;
    assign bus.out_read_mem  = slot_q.rm;
    assign bus.out_write_mem = slot_q.wm;
    assign bus.out_illegal   = slot_q.ill;
    assign bus.out_imm       = slot_q.imm;
    assign bus.out_pc        = pc_q;
endmodule
